// File: rtl/sfp_accum.sv
// Sequential accumulator for the 9-bit small-float format: sums NTERMS products
// per frame through an ALIGN/ADD/NORM pipeline and presents the sum under valid/ready.
module sfp_accum #(
    parameter int unsigned EXP_W  = 4,
    parameter int unsigned SIG_W  = 4,
    parameter int unsigned FMT_W  = 1 + EXP_W + SIG_W,
    parameter int unsigned NTERMS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FMT_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FMT_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int unsigned SW    = SIG_W + 2;
    localparam int unsigned CNT_W = $clog2(NTERMS + 1);
    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

    state_t           state;
    logic [FMT_W-1:0] acc;
    logic [FMT_W-1:0] opnd;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic [SW-1:0]    sig_l;
    logic [SW-1:0]    sig_s;
    logic [EXP_W-1:0] exp_l;
    logic             sign_l;
    logic             sub;
    logic [SW:0]      sum;

    logic [EXP_W-1:0] a_exp, b_exp, big_exp, small_exp, shamt;
    logic [SW-1:0]    a_sig, b_sig, big_sig, small_sig, small_shift;
    logic             a_big;

    // Operand alignment: zero operands carry no significand, the smaller one is shifted down
    always_comb begin
        a_exp       = acc[FMT_W-2 -: EXP_W];
        b_exp       = opnd[FMT_W-2 -: EXP_W];
        a_sig       = (a_exp == '0) ? '0 : {1'b1, acc[SIG_W-1:0], 1'b0};
        b_sig       = (b_exp == '0) ? '0 : {1'b1, opnd[SIG_W-1:0], 1'b0};
        a_big       = (b_exp == '0) || ((a_exp != '0) && (acc[FMT_W-2:0] >= opnd[FMT_W-2:0]));
        big_sig     = a_big ? a_sig : b_sig;
        small_sig   = a_big ? b_sig : a_sig;
        big_exp     = a_big ? a_exp : b_exp;
        small_exp   = a_big ? b_exp : a_exp;
        shamt       = big_exp - small_exp;
        small_shift = small_sig >> shamt;
    end

    int               lz;
    int               nexp;
    int               rexp;
    logic [SW-1:0]    nsig;
    logic [SIG_W:0]   rmant;
    logic [FMT_W-1:0] res;
    logic             sat;

    // Normalize, round half-up, then flush or saturate
    always_comb begin
        lz = int'(SW);
        for (int i = 0; i < int'(SW); i++)
            if (sum[i]) lz = int'(SW) - 1 - i;
        if (sum[SW]) begin
            nsig = sum[SW:1];
            nexp = int'(exp_l) + 1;
        end else begin
            nsig = SW'(sum[SW-1:0] << lz);
            nexp = int'(exp_l) - lz;
        end
        rmant = {1'b0, nsig[SW-2:1]} + (SIG_W+1)'(nsig[0]);
        rexp  = rmant[SIG_W] ? nexp + 1 : nexp;
        sat   = 1'b0;
        if (sum == '0 || nexp < 1) begin
            res = '0;
        end else if (rexp > int'(EXP_MAX)) begin
            res = {sign_l, {(FMT_W-1){1'b1}}};
            sat = 1'b1;
        end else begin
            res = {sign_l, EXP_W'(rexp), rmant[SIG_W-1:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            opnd      <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            sig_l     <= '0;
            sig_s     <= '0;
            exp_l     <= '0;
            sign_l    <= 1'b0;
            sub       <= 1'b0;
            sum       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        opnd     <= in_data;
                        count    <= count + CNT_W'(1);
                        in_ready <= 1'b0;
                        state    <= ALIGN;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ALIGN: begin
                    sig_l  <= big_sig;
                    sig_s  <= small_shift;
                    exp_l  <= big_exp;
                    sign_l <= a_big ? acc[FMT_W-1] : opnd[FMT_W-1];
                    sub    <= acc[FMT_W-1] ^ opnd[FMT_W-1];
                    state  <= ADD;
                end
                ADD: begin
                    sum   <= sub ? ({1'b0, sig_l} - {1'b0, sig_s})
                                 : ({1'b0, sig_l} + {1'b0, sig_s});
                    state <= NORM;
                end
                NORM: begin
                    acc <= res;
                    if (sat) ovf <= 1'b1;
                    if (count == CNT_W'(NTERMS)) begin
                        out_valid <= 1'b1;
                        out_data  <= res;
                        out_ovf   <= ovf | sat;
                        state     <= OUT;
                    end else begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfp_accum.sv
// Self-checking bench for sfp_accum: directed frames plus random frames against a value-level model.
module tb_sfp_accum;

    localparam int NT = 4;
    typedef logic [8:0] frame_t [NT];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [8:0] out_data;
    logic       out_ovf;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sfp_accum #(.EXP_W(4), .SIG_W(4), .FMT_W(9), .NTERMS(NT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    // Reference addition on integer magnitudes: value = (16+mant) << exp
    function automatic logic [9:0] m_add(input logic [8:0] a, input logic [8:0] b);
        int ea = int'(a[7:4]);
        int eb = int'(b[7:4]);
        int va, vb, vl, vs, gw, k, el, e;
        logic sl;
        va = (ea == 0) ? 0 : (16 + int'(a[3:0])) << ea;
        vb = (eb == 0) ? 0 : (16 + int'(b[3:0])) << eb;
        if (va >= vb) begin vl = va; vs = vb; el = ea; sl = a[8]; end
        else          begin vl = vb; vs = va; el = eb; sl = b[8]; end
        if (vl == 0) return 10'h000;
        gw = 1 << (el - 1);
        vs = (vs / gw) * gw;
        k = (a[8] == b[8]) ? (vl + vs) / gw : (vl - vs) / gw;
        if (k == 0) return 10'h000;
        e = el;
        while (k >= 64) begin k = k / 2; e++; end
        while (k < 32) begin k = k * 2; e--; end
        if (e < 1) return 10'h000;
        k = k / 2 + k % 2;
        if (k == 32) begin k = 16; e++; end
        if (e > 15) return {1'b1, sl, 8'hFF};
        return {1'b0, sl, 4'(e), 4'(k - 16)};
    endfunction

    function automatic logic [9:0] m_frame(input frame_t t);
        logic [8:0] acc = '0;
        logic       ovf = 1'b0;
        logic [9:0] r;
        for (int i = 0; i < NT; i++) begin
            r = m_add(acc, t[i]);
            acc = r[8:0];
            ovf = ovf | r[9];
        end
        return {ovf, acc};
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < NT; i++) begin
            f[i] = 9'($urandom);
            if ($urandom_range(0, 3) == 0) f[i][7:4] = 4'($urandom_range(6, 10));
        end
        return f;
    endfunction

    task automatic send_term(input logic [8:0] v);
        int w = 0;
        in_valid = 1'b1;
        in_data  = v;
        while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_term: in_ready=%b after %0d cycles, required 1", in_ready, w);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 9'($urandom);
    endtask

    task automatic run_frame(input frame_t t, output logic [8:0] d, output logic o, output int lat);
        for (int i = 0; i < NT; i++) send_term(t[i]);
        lat = 0;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        d = out_data;
        o = out_ovf;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({in_ready, out_valid, out_data, out_ovf} !== 12'h000) begin
            fails++;
            $display("FAIL reset_values: got rdy=%b vld=%b data=%h ovf=%b, required 0/0/000/0",
                     in_ready, out_valid, out_data, out_ovf);
        end
        @(negedge clk) rst_n = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready_early: got %b required 0", in_ready); end
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_rise: got %b required 1", in_ready); end
    endtask

    task automatic test_directed();
        frame_t vec [5];
        logic [8:0] expd [5];
        logic [8:0] d;
        logic o;
        int lat;
        vec[0] = '{9'h080, 9'h080, 9'h080, 9'h080}; expd[0] = 9'h0A0;
        vec[1] = '{9'h080, 9'h180, 9'h088, 9'h000}; expd[1] = 9'h088;
        vec[2] = '{9'h080, 9'h030, 9'h000, 9'h000}; expd[2] = 9'h081;
        vec[3] = '{9'h080, 9'h130, 9'h000, 9'h000}; expd[3] = 9'h07F;
        vec[4] = '{9'h080, 9'h00F, 9'h10A, 9'h080}; expd[4] = 9'h090;
        for (int i = 0; i < 5; i++) begin
            run_frame(vec[i], d, o, lat);
            tests++;
            if (d !== expd[i] || o !== 1'b0) begin
                fails++;
                $display("FAIL directed_%0d: got %h ovf=%b, required %h ovf=0", i, d, o, expd[i]);
            end
            tests++;
            if (lat !== 3) begin fails++; $display("FAIL directed_latency_%0d: got %0d required 3", i, lat); end
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                fails++;
                $display("FAIL directed_release_%0d: got vld=%b rdy=%b, required 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_saturation();
        logic [8:0] d;
        logic o;
        int lat;
        run_frame('{9'h0F8, 9'h0F8, 9'h0F8, 9'h0F8}, d, o, lat);
        tests++;
        if (d !== 9'h0FF || o !== 1'b1) begin
            fails++; $display("FAIL saturation: got %h ovf=%b, required 0ff ovf=1", d, o);
        end
        @(posedge clk); #1;
        run_frame('{9'h080, 9'h080, 9'h080, 9'h080}, d, o, lat);
        tests++;
        if (d !== 9'h0A0 || o !== 1'b0) begin
            fails++; $display("FAIL saturation_clear: got %h ovf=%b, required 0a0 ovf=0", d, o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        frame_t f;
        logic [9:0] e;
        logic [8:0] d;
        logic o;
        int lat;
        for (int n = 0; n < 40; n++) begin
            f = rand_frame();
            e = m_frame(f);
            run_frame(f, d, o, lat);
            tests++;
            if (d !== e[8:0] || o !== e[9] || lat !== 3) begin
                fails++;
                $display("FAIL random_%0d: terms %h %h %h %h got %h ovf=%b lat=%0d, required %h ovf=%b lat=3",
                         n, f[0], f[1], f[2], f[3], d, o, lat, e[8:0], e[9]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        frame_t f;
        logic [9:0] e;
        logic [8:0] d;
        logic o;
        int lat;
        f = rand_frame();
        e = m_frame(f);
        run_frame(f, d, o, lat);
        out_ready = 1'b0;
        tests++;
        if (d !== e[8:0] || o !== e[9]) begin
            fails++; $display("FAIL bp_value: got %h ovf=%b, required %h ovf=%b", d, o, e[8:0], e[9]);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'($urandom);
            in_data  = 9'($urandom);
            @(posedge clk); #1;
            tests++;
            if (out_valid !== 1'b1 || out_data !== e[8:0] || out_ovf !== e[9] || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold_%0d: got vld=%b data=%h ovf=%b rdy=%b, required 1/%h/%b/0",
                         c, out_valid, out_data, out_ovf, in_ready, e[8:0], e[9]);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_release: got vld=%b rdy=%b, required 0/1", out_valid, in_ready);
        end
        f = rand_frame();
        e = m_frame(f);
        run_frame(f, d, o, lat);
        tests++;
        if (d !== e[8:0] || o !== e[9]) begin
            fails++; $display("FAIL bp_next_frame: got %h ovf=%b, required %h ovf=%b", d, o, e[8:0], e[9]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        frame_t f1, f2;
        logic [9:0] e1, e2;
        logic [8:0] d;
        logic o;
        int lat, c1, c2;
        f1 = rand_frame(); e1 = m_frame(f1);
        f2 = rand_frame(); e2 = m_frame(f2);
        run_frame(f1, d, o, lat);
        c1 = cyc;
        tests++;
        if (d !== e1[8:0] || o !== e1[9]) begin
            fails++; $display("FAIL b2b_first: got %h ovf=%b, required %h ovf=%b", d, o, e1[8:0], e1[9]);
        end
        run_frame(f2, d, o, lat);
        c2 = cyc;
        tests++;
        if (d !== e2[8:0] || o !== e2[9]) begin
            fails++; $display("FAIL b2b_second: got %h ovf=%b, required %h ovf=%b", d, o, e2[8:0], e2[9]);
        end
        tests++;
        if (c2 - c1 !== 17) begin fails++; $display("FAIL b2b_period: got %0d cycles, required 17", c2 - c1); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [8:0] d;
        logic o;
        int lat;
        run_frame('{9'h0F8, 9'h0F8, 9'h0F8, 9'h0F8}, d, o, lat);
        @(posedge clk); #1;
        send_term(9'h090);
        send_term(9'h090);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({in_ready, out_valid, out_data, out_ovf} !== 12'h000) begin
            fails++;
            $display("FAIL reset_mid: got rdy=%b vld=%b data=%h ovf=%b, required 0/0/000/0",
                     in_ready, out_valid, out_data, out_ovf);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_mid_ready: got %b required 1", in_ready); end
        run_frame('{9'h090, 9'h090, 9'h000, 9'h000}, d, o, lat);
        tests++;
        if (d !== 9'h0A0 || o !== 1'b0 || lat !== 3) begin
            fails++; $display("FAIL reset_mid_fresh: got %h ovf=%b lat=%0d, required 0a0 ovf=0 lat=3", d, o, lat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_saturation();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d failures so far", fails);
        $fatal(1);
    end

endmodule
